// File: rtl/mod_n_down_timer.sv
// mod_n_down_timer: programmable mod-N down-counter/timer with load/start/pause control FSM
//
// Counts down from a loaded value to 0, then stops (one-shot) or reloads N-1
// (periodic), raising a one-cycle registered terminal-count pulse on each expiry.
//
// Parameters:
//   K  counter width in bits
//   N  modulus, reload value is N-1 (2 <= N <= 2^K)
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   load         load request, highest priority, returns to IDLE
//   load_val     value to load, saturated to N-1
//   start        start request, honoured only in IDLE or DONE
//   pause        level, freezes RUN while high
//   auto_reload  level, 1 = periodic, 0 = one-shot (sampled at count==0)
//   count        registered counter value
//   tc           registered one-cycle terminal-count pulse
//   busy         high in RUN or PAUSE
//   done         high in DONE
//   borrow_out   (only with TIMER_BORROW_OUT_EN) combinational cascade enable
//
// Optional feature macro: TIMER_BORROW_OUT_EN
module mod_n_down_timer #(
    parameter int K = 4,
    parameter int N = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [K-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [K-1:0] count,
    output logic         tc,
    output logic         busy,
    output logic         done
`ifdef TIMER_BORROW_OUT_EN
    ,
    output logic         borrow_out
`endif
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [K-1:0] RELOAD = K'(N - 1);

    state_t       state_q;
    logic [K-1:0] count_q;
    logic         tc_q;
    logic [K-1:0] load_sat;

    assign load_sat = (load_val > RELOAD) ? RELOAD : load_val;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (load) begin
                count_q <= load_sat;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_q <= RUN;
                            // A start from zero arms a full period instead of expiring at once
                            if (count_q == '0) count_q <= RELOAD;
                        end
                    end
                    RUN: begin
                        if (pause) state_q <= PAUSE;
                        else if (count_q != '0) count_q <= count_q - 1'b1;
                        else begin
                            tc_q <= 1'b1;
                            if (auto_reload) count_q <= RELOAD;
                            else state_q <= DONE;
                        end
                    end
                    default: begin
                        if (!pause) state_q <= RUN;
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN) || (state_q == PAUSE);
    assign done  = (state_q == DONE);

`ifdef TIMER_BORROW_OUT_EN
    // Fires in the same cycle the expiry edge will be taken, so a cascaded stage steps with no lag
    assign borrow_out = (state_q == RUN) && (count_q == '0) && !pause && !load;
`endif

endmodule
